// File: rtl/dr_sync_bridge.sv
// Clocked bridge between synchronous valid/ready byte streams and a pair of
// 4-phase return-to-zero dual-rail channels (one outbound, one inbound).
`timescale 1ns/1ps

module dr_sync_bridge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    // Streams use strict valid/ready: a beat moves on a rising edge where
    // valid and ready are both high; valid never waits on ready, and data is
    // held stable while valid is high and ready is low.
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] out_0r0,
    output logic [WIDTH-1:0] out_0r1,
    input  logic             out_0a,
    input  logic [WIDTH-1:0] in_0r0,
    input  logic [WIDTH-1:0] in_0r1,
    output logic             in_0a,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             rx_err,
    output logic [1:0]       dbg_tx_state_o,
    output logic             dbg_rx_state_o
);

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_DATA = 2'd1,
        T_RTZ  = 2'd2
    } tx_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_e;

    // ------------------------------------------------------------------
    // Synchronizers for every signal that comes from the asynchronous core
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic [SYNC_STAGES-1:0] comp_sync_q;
    logic [SYNC_STAGES-1:0] empty_sync_q;
    logic                   comp_raw;
    logic                   empty_raw;
    logic                   ack_s;
    logic                   comp_s;
    logic                   empty_s;

    assign comp_raw  = &(in_0r0 | in_0r1);
    assign empty_raw = ~|(in_0r0 | in_0r1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_sync_q   <= '0;
            comp_sync_q  <= '0;
            empty_sync_q <= '0;
        end else begin
            ack_sync_q   <= {ack_sync_q[SYNC_STAGES-2:0], out_0a};
            comp_sync_q  <= {comp_sync_q[SYNC_STAGES-2:0], comp_raw};
            empty_sync_q <= {empty_sync_q[SYNC_STAGES-2:0], empty_raw};
        end
    end

    assign ack_s   = ack_sync_q[SYNC_STAGES-1];
    assign comp_s  = comp_sync_q[SYNC_STAGES-1];
    assign empty_s = empty_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Transmit half: the rail flops themselves hold the codeword, so every
    // bit switches from a register and the rails never pass through 1/1.
    // ------------------------------------------------------------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [WIDTH-1:0] tx_r0_q, tx_r0_d;
    logic [WIDTH-1:0] tx_r1_q, tx_r1_d;
    logic             s_ready_q, s_ready_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_r0_d    = tx_r0_q;
        tx_r1_d    = tx_r1_q;
        s_ready_d  = s_ready_q;
        case (tx_state_q)
            T_IDLE: begin
                if (s_valid && s_ready_q) begin
                    tx_r1_d    = s_data;
                    tx_r0_d    = ~s_data;
                    s_ready_d  = 1'b0;
                    tx_state_d = T_DATA;
                end else begin
                    s_ready_d = 1'b1;
                end
            end
            T_DATA: begin
                s_ready_d = 1'b0;
                if (ack_s) begin
                    tx_r0_d    = '0;
                    tx_r1_d    = '0;
                    tx_state_d = T_RTZ;
                end
            end
            T_RTZ: begin
                s_ready_d = 1'b0;
                if (!ack_s) begin
                    s_ready_d  = 1'b1;
                    tx_state_d = T_IDLE;
                end
            end
            default: begin
                tx_r0_d    = '0;
                tx_r1_d    = '0;
                s_ready_d  = 1'b0;
                tx_state_d = T_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= T_IDLE;
            tx_r0_q    <= '0;
            tx_r1_q    <= '0;
            s_ready_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_r0_q    <= tx_r0_d;
            tx_r1_q    <= tx_r1_d;
            s_ready_q  <= s_ready_d;
        end
    end

    assign out_0r0        = tx_r0_q;
    assign out_0r1        = tx_r1_q;
    assign s_ready        = s_ready_q;
    assign dbg_tx_state_o = tx_state_q;

    // ------------------------------------------------------------------
    // Receive half: data rails are sampled unsynchronized, only once the
    // synchronized completion flag shows them settled; the sender cannot
    // move them again until in_0a rises.
    // ------------------------------------------------------------------
    rx_state_e        rx_state_q, rx_state_d;
    logic             in_0a_q, in_0a_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             rx_err_q, rx_err_d;

    always_comb begin
        rx_state_d = rx_state_q;
        in_0a_d    = in_0a_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        rx_err_d   = rx_err_q;
        // Consumption is independent of the FSM; capture needs m_valid low,
        // so the two never collide.
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        case (rx_state_q)
            R_IDLE: begin
                in_0a_d = 1'b0;
                if (comp_s && !m_valid_q) begin
                    m_data_d   = in_0r1;
                    m_valid_d  = 1'b1;
                    in_0a_d    = 1'b1;
                    rx_state_d = R_ACK;
                    if (|(in_0r0 & in_0r1)) begin
                        rx_err_d = 1'b1;
                    end
                end
            end
            R_ACK: begin
                in_0a_d = 1'b1;
                if (empty_s) begin
                    in_0a_d    = 1'b0;
                    rx_state_d = R_IDLE;
                end
            end
            default: begin
                in_0a_d    = 1'b0;
                rx_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= R_IDLE;
            in_0a_q    <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            in_0a_q    <= in_0a_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign in_0a          = in_0a_q;
    assign m_data         = m_data_q;
    assign m_valid        = m_valid_q;
    assign rx_err         = rx_err_q;
    assign dbg_rx_state_o = rx_state_q;

endmodule

// File: tb/tb_dr_sync_bridge.sv
// Directed bench for dr_sync_bridge: reset, TX and RX handshakes, backpressure,
// partial/erroneous codewords, and a delayed loopback stream with mid-run reset.
`timescale 1ns/1ps

module tb_dr_sync_bridge;
  localparam int WIDTH = 8;
  localparam int SS    = 2;
  localparam int LAT   = SS + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] out_0r0, out_0r1;
  logic             out_0a;
  logic [WIDTH-1:0] in_0r0, in_0r1;
  logic             in_0a;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             rx_err;
  logic [1:0]       dbg_tx_state_o;
  logic             dbg_rx_state_o;

  // Directly driven channel values, or a 5 ns wire-delay loopback.
  logic             loop_en;
  logic [WIDTH-1:0] tb_r0, tb_r1;
  logic             tb_ack;
  logic [WIDTH-1:0] lb_r0, lb_r1;
  logic             lb_ack;

  assign #5 lb_r0  = out_0r0;
  assign #5 lb_r1  = out_0r1;
  assign #5 lb_ack = in_0a;

  assign in_0r0 = loop_en ? lb_r0 : tb_r0;
  assign in_0r1 = loop_en ? lb_r1 : tb_r1;
  assign out_0a = loop_en ? lb_ack : tb_ack;

  dr_sync_bridge #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .out_0r0        (out_0r0),
    .out_0r1        (out_0r1),
    .out_0a         (out_0a),
    .in_0r0         (in_0r0),
    .in_0r1         (in_0r1),
    .in_0a          (in_0a),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .rx_err         (rx_err),
    .dbg_tx_state_o (dbg_tx_state_o),
    .dbg_rx_state_o (dbg_rx_state_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int  acc_cnt = 0;
  int  rx_cnt  = 0;
  bit  sb_en   = 1'b0;

  always @(posedge clk) begin
    if (reset && s_valid && s_ready) begin
      acc_cnt++;
      if (sb_en) exp_q.push_back(s_data);
    end
  end

  always @(negedge clk) begin
    if (reset && sb_en && m_valid && m_ready) begin
      if (exp_q.size() == 0) check_eq("sb_queue_nonempty", exp_q.size(), 1);
      else check_eq("sb_data", m_data, exp_q.pop_front());
      rx_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rx_drive(input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r0);
    tb_r1 = r1;
    tb_r0 = r0;
  endtask

  task automatic wait_in_0a(input logic lvl, output int k);
    k = 0;
    while (in_0a !== lvl && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic consume();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic tx_stream(input int n, input int stop_after);
    for (int v = 0; v < n; v++) begin
      int c0;
      int k;
      s_data  = v[WIDTH-1:0];
      s_valid = 1'b1;
      c0 = acc_cnt;
      k  = 0;
      while (acc_cnt == c0 && k < 60) begin
        @(negedge clk);
        k++;
      end
      check_eq("tx_accept", acc_cnt - c0, 1);
      if (v == stop_after) break;
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    reset   = 1'b0;
    loop_en = 1'b0;
    s_data  = 8'h5A;
    s_valid = 1'b1;
    m_ready = 1'b0;
    tb_r1   = 8'hFF;
    tb_r0   = 8'h00;
    tb_ack  = 1'b0;

    // Reset holds every output low even with live inputs.
    repeat (3) @(negedge clk);
    check_eq("rst_out_0r0", out_0r0, 0);
    check_eq("rst_out_0r1", out_0r1, 0);
    check_eq("rst_in_0a", in_0a, 0);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_rx_err", rx_err, 0);
    s_valid = 1'b0;
    tb_r1   = 8'h00;
    reset   = 1'b1;
    @(negedge clk);
    check_eq("rel_s_ready", s_ready, 1);

    // TX single transfer.
    s_data  = 8'hA5;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check_eq("tx_r1", out_0r1, 8'hA5);
    check_eq("tx_r0", out_0r0, 8'h5A);
    check_eq("tx_busy_ready", s_ready, 0);
    check_eq("tx_state_data", dbg_tx_state_o, 1);
    repeat (2) @(negedge clk);
    check_eq("tx_r1_hold", out_0r1, 8'hA5);
    tb_ack = 1'b1;
    k = 0;
    while (out_0r1 !== 8'h00 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_eq("tx_rtz_latency", k, LAT);
    check_eq("tx_rtz_r0", out_0r0, 0);
    check_eq("tx_rtz_ready", s_ready, 0);
    repeat (2) @(negedge clk);
    check_eq("tx_ack_hi_ready", s_ready, 0);
    check_eq("tx_state_rtz", dbg_tx_state_o, 2);
    tb_ack = 1'b0;
    k = 0;
    while (s_ready !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_eq("tx_ready_latency", k, LAT);

    // RX single transfer.
    rx_drive(8'h3C, 8'hC3);
    wait_in_0a(1'b1, k);
    check_eq("rx_ack_latency", k, LAT);
    check_eq("rx_m_valid", m_valid, 1);
    check_eq("rx_m_data", m_data, 8'h3C);
    check_eq("rx_state_ack", dbg_rx_state_o, 1);
    check_eq("rx_no_err", rx_err, 0);
    rx_drive(8'h00, 8'h00);
    wait_in_0a(1'b0, k);
    check_eq("rx_rtz_latency", k, LAT);
    check_eq("rx_hold_valid", m_valid, 1);
    consume();
    check_eq("rx_consumed", m_valid, 0);

    // RX backpressure: second codeword must wait for the first to drain.
    rx_drive(8'h11, 8'hEE);
    wait_in_0a(1'b1, k);
    check_eq("bp_first_data", m_data, 8'h11);
    rx_drive(8'h00, 8'h00);
    wait_in_0a(1'b0, k);
    check_eq("bp_first_rtz", in_0a, 0);
    rx_drive(8'h22, 8'hDD);
    repeat (6) @(negedge clk);
    check_eq("bp_stall_ack", in_0a, 0);
    check_eq("bp_stall_data", m_data, 8'h11);
    check_eq("bp_stall_valid", m_valid, 1);
    consume();
    check_eq("bp_drained", m_valid, 0);
    @(negedge clk);
    check_eq("bp_second_valid", m_valid, 1);
    check_eq("bp_second_data", m_data, 8'h22);
    check_eq("bp_second_ack", in_0a, 1);
    rx_drive(8'h00, 8'h00);
    wait_in_0a(1'b0, k);
    consume();

    // Partial codeword is ignored; completing with a double-rail bit flags an error.
    rx_drive(8'hFE, 8'h00);
    repeat (6) @(negedge clk);
    check_eq("part_no_ack", in_0a, 0);
    check_eq("part_no_valid", m_valid, 0);
    rx_drive(8'hFF, 8'h01);
    wait_in_0a(1'b1, k);
    check_eq("err_ack_latency", k, LAT);
    check_eq("err_m_data", m_data, 8'hFF);
    check_eq("err_flag", rx_err, 1);
    rx_drive(8'h00, 8'h00);
    wait_in_0a(1'b0, k);
    consume();
    rx_drive(8'h5A, 8'hA5);
    wait_in_0a(1'b1, k);
    check_eq("clean_after_err_data", m_data, 8'h5A);
    check_eq("err_sticky", rx_err, 1);
    rx_drive(8'h00, 8'h00);
    wait_in_0a(1'b0, k);
    consume();

    // Loopback stream, full byte range.
    loop_en = 1'b1;
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    sb_en  = 1'b1;
    rx_cnt = 0;
    tx_stream(256, -1);
    k = 0;
    while (rx_cnt < 256 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("lb_count", rx_cnt, 256);
    check_eq("lb_queue_empty", exp_q.size(), 0);

    // Loopback again, reset while a codeword is on the rails.
    rx_cnt = 0;
    tx_stream(256, 40);
    check_eq("mid_rails_live", out_0r1, 40);
    check_eq("mid_rx_count", rx_cnt, 40);
    check_eq("mid_queue_inflight", exp_q.size(), 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_async_r1", out_0r1, 0);
    check_eq("mid_async_r0", out_0r0, 0);
    check_eq("mid_async_ready", s_ready, 0);
    check_eq("mid_async_in_0a", in_0a, 0);
    check_eq("mid_async_m_valid", m_valid, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    rx_cnt = 0;
    repeat (4) @(negedge clk);
    check_eq("restart_rails_idle", out_0r1, 0);
    check_eq("restart_ready", s_ready, 1);
    tx_stream(256, -1);
    k = 0;
    while (rx_cnt < 256 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("restart_count", rx_cnt, 256);
    check_eq("restart_queue_empty", exp_q.size(), 0);
    check_eq("restart_no_err", rx_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dr_sync_bridge.md
Name: dr_sync_bridge

Overview:
- Clocked adapter that sits directly beside teak_top.
- Transmit half: converts a synchronous valid/ready byte stream into a 4-phase return-to-zero dual-rail channel that drives a teak_top input port (e.g. iout_0r0/iout_0r1/iout_0a).
- Receive half: consumes a teak_top dual-rail output port (e.g. iin_0r0/iin_0r1/iin_0a) and presents it as a synchronous valid/ready stream.
- Lets clocked logic and FPGA harnesses source and sink the asynchronous core without a behavioural bench.

Parameters:
WIDTH, 8, data bits per channel
SYNC_STAGES, 2, flip-flop depth of each synchronizer on asynchronous inputs (min 2)

Ports:
clk  input  1  single clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
s_data  input  WIDTH  transmit data
s_valid  input  1  transmit data valid
s_ready  output  1  transmit accept
out_0r0  output  WIDTH  dual-rail false rails to DUT input channel
out_0r1  output  WIDTH  dual-rail true rails to DUT input channel
out_0a  input  1  acknowledge from DUT (asynchronous)
in_0r0  input  WIDTH  dual-rail false rails from DUT output channel (asynchronous)
in_0r1  input  WIDTH  dual-rail true rails from DUT output channel (asynchronous)
in_0a  output  1  acknowledge to DUT
m_data  output  WIDTH  received data (true rails)
m_valid  output  1  received data valid
m_ready  input  1  downstream accept
rx_err  output  1  sticky protocol error: some bit had both rails high at capture

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: out_0r0=0, out_0r1=0, in_0a=0, s_ready=0, m_valid=0, m_data=0, rx_err=0.
  - FSMs go to IDLE; synchronizers are cleared.
  - Outputs take their reset values immediately, with no clock.
  - Reset mid-handshake abandons the transfer; the DUT is reset at the same time.
- Synchronizers: out_0a is passed through SYNC_STAGES flops to give ack_s.
- TX FSM states: T_IDLE, T_DATA, T_RTZ.
  - T_IDLE: s_ready=1; rails all zero.
    - When s_valid & s_ready, register s_data.
    - On the next edge drive out_0r1=data and out_0r0=~data (all WIDTH bits together, from flops, glitch-free) and enter T_DATA.
  - T_DATA: s_ready=0; rails held stable. When ack_s=1, clear both rails to zero and enter T_RTZ.
  - T_RTZ: s_ready=0. When ack_s=0, enter T_IDLE; s_ready rises that same edge.
  - Latency: rails valid 1 cycle after acceptance. Minimum cycle is about 2*SYNC_STAGES+3 clocks per transfer.
  - No other rail value combinations are ever driven; both rails of a bit are never high together.
- RX completion detect:
  - comp = &(in_0r0|in_0r1) and empty = ~|(in_0r0|in_0r1), each formed combinationally.
  - Each is synchronized through SYNC_STAGES to give comp_s and empty_s.
  - Data rails are not synchronized. They are sampled only after comp_s=1; the 4-phase protocol holds them stable until in_0a rises.
- RX FSM states: R_IDLE, R_ACK.
  - R_IDLE: in_0a=0. If comp_s=1 and m_valid=0:
    - m_data <= in_0r1; m_valid <= 1; in_0a <= 1; enter R_ACK.
    - If |(in_0r0&in_0r1), set rx_err=1 (sticky until reset).
  - R_IDLE while comp_s=1 and m_valid=1: wait (backpressure). in_0a stays low, so the DUT stalls.
  - R_ACK: in_0a=1. When empty_s=1, in_0a <= 0 and enter R_IDLE.
  - Partially-complete codewords (comp=0, empty=0) are never captured.
- Output register:
  - m_valid clears on m_valid & m_ready.
  - m_data is held while m_valid=1.
  - The clear is independent of the RX FSM state.
  - Capture and clear in the same cycle cannot occur, because capture requires m_valid=0.
- TX and RX halves are fully independent and may operate concurrently.

Test Plan:
- Reset: hold reset=0 with in_0r1=8'hFF and s_valid=1 -> all outputs 0, rx_err=0. Release reset -> s_ready=1 on the first edge.
- TX single transfer: s_data=8'hA5 accepted. Next cycle out_0r1=8'hA5, out_0r0=8'h5A. Model acks after 3 cycles -> rails go 0 within SYNC_STAGES+1 cycles of ack. s_ready returns 1 only after ack drops.
- RX single transfer: drive in_0r1=8'h3C, in_0r0=8'hC3 -> m_valid=1, m_data=8'h3C, in_0a=1. Return rails to 0 -> in_0a=0. m_ready=1 -> m_valid=0.
- RX backpressure: m_ready=0, send 8'h11 then 8'h22 -> second codeword is not acked; in_0a stays 0 until m_ready pulses. Then m_data=8'h22.
- Partial codeword and error: raise 7 of 8 bits -> no capture, in_0a=0. Complete with bit0 driven on both rails -> capture occurs, rx_err=1, and rx_err stays 1 after later clean transfers.
- Loopback with reset mid-operation: TX->RX through a 5 ns delay model, stream 8'h00..8'hFF -> 256 in-order matches. Repeat, asserting reset while out_0r1≠0 -> rails are 0 asynchronously and the stream restarts cleanly after release.
